// File: rtl/fetch_unit_if.sv
// IF-stage bus bundle: hazard/redirect controls, instruction-memory port and IF/ID write side.
// Perf-counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        ifid_en;
    logic [15:0] ifid_opc;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cycles;
    logic [15:0] redirects;
`endif

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata, imem_valid,
        output imem_req, imem_addr, ifid_en, ifid_opc, ifid_pc, ifid_instr, halted
`ifdef FETCH_PERF_CNT_EN
        , output miss_cycles, redirects
`endif
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata, imem_valid,
        input  imem_req, imem_addr, ifid_en, ifid_opc, ifid_pc, ifid_instr, halted
`ifdef FETCH_PERF_CNT_EN
        , input miss_cycles, redirects
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, RUN/MISS/HALT sequencing, IF/ID write side.
// Optional saturating perf counters enabled by the FETCH_PERF_CNT_EN macro.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HLT_OPC   = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_plus2;
    logic        en_raw;
    logic [15:0] instr_d;

    assign pc_plus2 = pc_q + 16'd2;

    // Priority: branch_taken > HALT parking > stall > imem_valid.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        en_raw  = 1'b0;
        instr_d = NOP_INSTR;
        if (bus.branch_taken) begin
            pc_d    = bus.branch_target;
            state_d = RUN;
            en_raw  = 1'b1;
        end else if (state_q == HALT) begin
            en_raw  = 1'b1;
        end else if (bus.stall) begin
            if (state_q == RUN && !bus.imem_valid)
                state_d = MISS;
        end else if (bus.imem_valid) begin
            en_raw  = 1'b1;
            instr_d = bus.imem_rdata;
            if (bus.imem_rdata[15:12] == HLT_OPC) begin
                state_d = HALT;
            end else begin
                pc_d    = pc_plus2;
                state_d = RUN;
            end
        end else begin
            en_raw  = 1'b1;
            state_d = MISS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = (state_q != HALT);
    assign bus.ifid_en    = rst & en_raw;
    assign bus.ifid_opc   = pc_q;
    assign bus.ifid_pc    = pc_plus2;
    assign bus.ifid_instr = instr_d;
    assign bus.halted     = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cycles_q, redirects_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cycles_q <= '0;
            redirects_q   <= '0;
        end else begin
            if (state_q == MISS && miss_cycles_q != '1)
                miss_cycles_q <= miss_cycles_q + 16'd1;
            if (bus.branch_taken && redirects_q != '1)
                redirects_q <= redirects_q + 16'd1;
        end
    end

    assign bus.miss_cycles = miss_cycles_q;
    assign bus.redirects   = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; perf counters are exercised when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000),
        .HLT_OPC   (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = 16'h0000;
        bus.imem_valid     = 1'b1;
        bus.imem_rdata     = 16'h1234;

        // reset state
        #2;
        check("rst_en",     {15'd0, bus.ifid_en},  16'h0000);
        check("rst_req",    {15'd0, bus.imem_req}, 16'h0001);
        check("rst_addr",   bus.imem_addr,         16'h0000);
        check("rst_halted", {15'd0, bus.halted},   16'h0000);
        #10 rst = 1'b1;   // t=12, away from edges
        #1;

        // sequential hits
        check("hit0_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("hit0_opc",   bus.ifid_opc,   16'h0000);
        check("hit0_pc",    bus.ifid_pc,    16'h0002);
        check("hit0_instr", bus.ifid_instr, 16'h1234);
        tick();
        check("hit1_opc",   bus.ifid_opc,   16'h0002);
        check("hit1_pc",    bus.ifid_pc,    16'h0004);
        tick();
        check("hit2_opc",   bus.ifid_opc,   16'h0004);
        check("hit2_pc",    bus.ifid_pc,    16'h0006);
        check("hit2_halt",  {15'd0, bus.halted}, 16'h0000);

        // redirect to 0x0010
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0010;
        #1;
        check("br10_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("br10_instr", bus.ifid_instr, 16'h0000);
        tick();
        bus.branch_taken = 1'b0;
        check("br10_addr",  bus.imem_addr, 16'h0010);

        // 3-cycle miss
        bus.imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("miss_en",    {15'd0, bus.ifid_en}, 16'h0001);
            check("miss_instr", bus.ifid_instr, 16'h0000);
            check("miss_opc",   bus.ifid_opc,   16'h0010);
            tick();
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'h4321;
        #1;
        check("missdone_instr", bus.ifid_instr, 16'h4321);
        check("missdone_opc",   bus.ifid_opc,   16'h0010);
        tick();
        check("missdone_addr",  bus.imem_addr,  16'h0012);

        // 2-cycle stall at 0x0020
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0020;
        tick();
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b1;
        bus.imem_rdata   = 16'h5555;
        #1;
        check("stall0_en",   {15'd0, bus.ifid_en}, 16'h0000);
        tick();
        check("stall1_en",   {15'd0, bus.ifid_en}, 16'h0000);
        check("stall1_addr", bus.imem_addr, 16'h0020);
        tick();
        bus.stall = 1'b0;
        #1;
        check("unstall_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("unstall_opc",   bus.ifid_opc,   16'h0020);
        check("unstall_instr", bus.ifid_instr, 16'h5555);
        tick();
        check("unstall_addr",  bus.imem_addr,  16'h0022);

        // branch with stall asserted
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0100;
        #1;
        check("brstall_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("brstall_instr", bus.ifid_instr, 16'h0000);
        tick();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.imem_rdata   = 16'h1111;
        #1;
        check("brstall_addr",  bus.imem_addr,  16'h0100);
        check("brstall_run",   bus.ifid_instr, 16'h1111);
        tick();

        // branch during a miss, landing on HLT
        bus.imem_valid = 1'b0;
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0030;
        #1;
        check("brmiss_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("brmiss_instr", bus.ifid_instr, 16'h0000);
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_valid   = 1'b1;
        bus.imem_rdata   = 16'hF000;
        #1;
        check("hlt_addr",   bus.imem_addr,  16'h0030);
        check("hlt_instr",  bus.ifid_instr, 16'hF000);
        check("hlt_pre",    {15'd0, bus.halted}, 16'h0000);
        tick();
        check("halted",     {15'd0, bus.halted},   16'h0001);
        check("halt_req",   {15'd0, bus.imem_req}, 16'h0000);
        check("halt_addr",  bus.imem_addr,  16'h0030);
        check("halt_instr", bus.ifid_instr, 16'h0000);
        tick();
        check("halt_hold",  bus.imem_addr,  16'h0030);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_rdata   = 16'hE000;
        #1;
        check("unhalt",      {15'd0, bus.halted},   16'h0000);
        check("unhalt_req",  {15'd0, bus.imem_req}, 16'h0001);
        check("unhalt_addr", bus.imem_addr,  16'h0040);
        tick();
        check("nothlt_halt", {15'd0, bus.halted}, 16'h0000);
        check("nothlt_addr", bus.imem_addr, 16'h0042);

        // PC+2 wrap
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'hFFFE;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_rdata   = 16'h2222;
        #1;
        check("wrap_opc", bus.ifid_opc, 16'hFFFE);
        check("wrap_pc",  bus.ifid_pc,  16'h0000);
        tick();
        check("wrap_addr", bus.imem_addr, 16'h0000);

        // async reset in the middle of a miss
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0050;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_valid   = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_addr", bus.imem_addr, 16'h0000);
        check("arst_en",   {15'd0, bus.ifid_en},  16'h0000);
        check("arst_req",  {15'd0, bus.imem_req}, 16'h0001);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'h3333;
        #2 rst = 1'b1;
        #1;
        check("arst_rel_en",    {15'd0, bus.ifid_en}, 16'h0001);
        check("arst_rel_instr", bus.ifid_instr, 16'h3333);
        check("arst_rel_opc",   bus.ifid_opc,   16'h0000);

`ifdef FETCH_PERF_CNT_EN
        check("perf_miss0", bus.miss_cycles, 16'h0000);
        check("perf_redir0", bus.redirects,  16'h0000);
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0060;
        tick();
        bus.branch_taken = 1'b0;
        check("perf_redir1", bus.redirects, 16'h0001);
        bus.imem_valid = 1'b0;
        tick();
        tick();
        tick();
        check("perf_miss2", bus.miss_cycles, 16'h0002);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check("perf_miss_sat", bus.miss_cycles, 16'hFFFF);
        bus.imem_valid = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the write side of the IF/ID pipeline register. It holds the PC and issues requests to a variable-latency instruction memory. Each cycle it presents the PC, PC+2 and instruction (or a bubble) plus a write enable to IF/ID. It handles hazard stalls, taken-branch redirects from the execute stage, instruction-memory misses and HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, bubble instruction written into IF/ID (ADD R0,R0,R0)
- HLT_OPC, 4'hF, opcode field value (instr[15:12]) identifying HLT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- stall  in  1  hazard stall from ID; hold PC and IF/ID contents
- branch_taken  in  1  taken branch/jump resolved downstream; redirect this cycle
- branch_target  in  16  redirect PC
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address (always equals current PC)
- imem_rdata  in  16  instruction data; meaningful only when imem_valid=1
- imem_valid  in  1  data valid for imem_addr in this cycle (hit or miss completion)
- ifid_en  out  1  IF/ID write enable
- ifid_opc  out  16  PC of the delivered instruction
- ifid_pc  out  16  PC+2 of the delivered instruction
- ifid_instr  out  16  delivered instruction or NOP_INSTR
- halted  out  1  fetch is parked on HLT

## Operation
- Registered state: pc[15:0] and a 2-bit FSM with states RUN, MISS and HALT. All other outputs are combinational from state, pc and inputs.
- imem_addr = pc. imem_req = 1 in RUN and MISS, 0 in HALT. ifid_opc = pc. ifid_pc = pc+2, computed mod 2^16 (0xFFFE wraps to 0x0000).
- Priority of events: reset > branch_taken > stall > imem_valid.
- branch_taken=1, in any state:
  - pc <= branch_target; state <= RUN.
  - ifid_en=1 and ifid_instr=NOP_INSTR, which flushes IF/ID even if stall=1.
  - Any outstanding miss is abandoned. The memory must accept an address change on any cycle.
- RUN/MISS, stall=1, no branch: ifid_en=0; pc and state held. In RUN, imem_valid=0 still moves the state to MISS.
- RUN/MISS, imem_valid=1, no stall, no branch:
  - ifid_en=1 and ifid_instr=imem_rdata.
  - If imem_rdata[15:12]==HLT_OPC: pc is held and state <= HALT.
  - Otherwise: pc <= pc+2 and state <= RUN.
- RUN/MISS, imem_valid=0, no stall, no branch: ifid_en=1, ifid_instr=NOP_INSTR (bubble); pc held; state <= MISS.
- HALT: halted=1, ifid_en=1, ifid_instr=NOP_INSTR, pc held. The only exit is branch_taken, because a speculatively fetched HLT may be on the wrong path.
- Reset (asserted, asynchronously): pc=RESET_PC, state=RUN.
  - Outputs while in reset: imem_req=1, imem_addr=RESET_PC, halted=0.
  - ifid_en is forced to 0 while rst=0.
  - Reset asserted mid-miss abandons the miss.

## Timing
- Fetch is single-cycle on a hit: the address is issued and the instruction is written into IF/ID at the same clock edge, and pc advances at that edge.
- Miss of N cycles (imem_valid low for N cycles, then high): N bubbles enter IF/ID, and the real instruction enters at edge N+1.
- Redirect: the branch_target instruction is requested in the cycle after branch_taken. Exactly one bubble is inserted per redirect cycle.
- Stall has no latency: the IF/ID enable drops in the same cycle stall is asserted. Fetch resumes in the cycle stall deasserts, with the same pc.
- The first request is issued in the first cycle after rst deasserts.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds output miss_cycles[15:0]: a saturating count of cycles spent in MISS state (0xFFFF holds).
  - Adds output redirects[15:0]: a saturating count of branch_taken cycles.
  - Both counters reset to 0 on rst.
- Not defined: neither port nor its counter logic exists; behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=0, imem_valid=1, rdata=16'h1234 each cycle -> ifid_opc sequence 0x0000, 0x0002, 0x0004; ifid_pc sequence 0x0002, 0x0004, 0x0006; ifid_en=1; halted=0.
- Miss: imem_valid held low 3 cycles at pc=0x0010 -> three NOP_INSTR writes with ifid_opc=0x0010, then the instruction is delivered and pc becomes 0x0012.
- Stall for 2 cycles at pc=0x0020 with imem_valid=1 -> ifid_en=0 for both cycles, pc stays 0x0020, next cycle delivers 0x0020.
- branch_taken=1 with target 0x0100, asserted together with stall=1 and during a miss -> ifid_en=1 with NOP_INSTR, next imem_addr=0x0100, state RUN.
- imem_rdata=16'hF000 at pc=0x0030 -> HLT written once, then halted=1, imem_req=0, pc stays 0x0030. Later branch_taken to 0x0040 -> halted=0 and fetch resumes at 0x0040.
- Async reset asserted mid-cycle during MISS -> pc=RESET_PC and ifid_en=0 immediately. With FETCH_PERF_CNT_EN defined: 70000 miss cycles -> miss_cycles=0xFFFF.
